// File: rtl/xgmii_rx_link_monitor.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_rx_link_monitor
// Brief    : RX-domain link debounce, SFP LED drive and saturating status
//            counters. Define LINK_MON_ERR_CNT_EN to build the error counter.
// Revision : 1.0 - initial release
// ============================================================================
module xgmii_rx_link_monitor #(
    parameter int LOCK_CYCLES = 1024,
    parameter int ACT_STRETCH = 8000000,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_block_lock,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 clear_cnt,
    output logic                 link_up,
    output logic                 led_link,
    output logic                 led_act,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] lock_loss_cnt
);

    localparam int LK_W  = $clog2(LOCK_CYCLES + 1);
    localparam int ACT_W = $clog2(ACT_STRETCH + 1);

    localparam logic [LK_W-1:0]  c_LK_ONE   = LK_W'(1);
    localparam logic [LK_W-1:0]  c_LK_LAST  = LK_W'(LOCK_CYCLES - 1);
    localparam logic [ACT_W-1:0] c_ACT_LOAD = ACT_W'(ACT_STRETCH);
    localparam logic [ACT_W-1:0] c_ACT_ONE  = ACT_W'(1);
    localparam logic [7:0]       c_SOF      = 8'hFB;

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_WAIT = 2'd1,
        ST_UP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [LK_W-1:0]  r_lk;
    logic             r_link_up;
    logic [ACT_W-1:0] r_act;
    logic             r_led_act;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [CNT_WIDTH-1:0] r_lock_loss_cnt;

    // Adds 0..2, clamping at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(inc);
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_DOWN;
            r_lk      <= '0;
            r_link_up <= 1'b0;
        end else begin
            case (r_state)
                ST_DOWN: begin
                    if (rx_block_lock) begin
                        r_lk <= c_LK_ONE;
                        if (LOCK_CYCLES == 1) begin
                            r_state   <= ST_UP;
                            r_link_up <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_lk <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!rx_block_lock) begin
                        r_state <= ST_DOWN;
                        r_lk    <= '0;
                    end else if (r_lk == c_LK_LAST) begin
                        r_state   <= ST_UP;
                        r_link_up <= 1'b1;
                    end else begin
                        r_lk <= r_lk + c_LK_ONE;
                    end
                end
                ST_UP: begin
                    if (!rx_block_lock) begin
                        r_state   <= ST_DOWN;
                        r_lk      <= '0;
                        r_link_up <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_DOWN;
                    r_lk      <= '0;
                    r_link_up <= 1'b0;
                end
            endcase
        end
    end

    // Counting is gated on the state before the edge, so transition cycles
    // follow the old state.
    logic       w_in_up;
    logic       w_lock_drop;
    logic       w_sof0;
    logic       w_sof4;
    logic       w_sof_any;
    logic [1:0] w_frame_inc;

    assign w_in_up     = (r_state == ST_UP);
    assign w_lock_drop = w_in_up & ~rx_block_lock;
    assign w_sof0      = xgmii_rxc[0] & (xgmii_rxd[7:0]   == c_SOF);
    assign w_sof4      = xgmii_rxc[4] & (xgmii_rxd[39:32] == c_SOF);
    assign w_sof_any   = w_sof0 | w_sof4;
    assign w_frame_inc = {w_sof0 & w_sof4, w_sof0 ^ w_sof4};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt     <= '0;
            r_lock_loss_cnt <= '0;
        end else if (clear_cnt) begin
            r_frame_cnt     <= '0;
            r_lock_loss_cnt <= '0;
        end else begin
            if (w_in_up && w_sof_any) begin
                r_frame_cnt <= sat_add(r_frame_cnt, w_frame_inc);
            end
            if (w_lock_drop) begin
                r_lock_loss_cnt <= sat_add(r_lock_loss_cnt, 2'd1);
            end
        end
    end

`ifdef LINK_MON_ERR_CNT_EN
    logic [7:0]           w_err_lane;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    for (genvar k = 0; k < 8; k++) begin : g_err_lane
        assign w_err_lane[k] = xgmii_rxc[k] & (xgmii_rxd[8*k +: 8] == 8'hFE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clear_cnt) begin
            r_err_cnt <= '0;
        end else if (w_in_up && (|w_err_lane)) begin
            r_err_cnt <= sat_add(r_err_cnt, 2'd1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_rx;
    assign w_unused_rx = ^{xgmii_rxd, xgmii_rxc};
    assign err_cnt     = '0;
`endif

    // Starts reload the stretch timer in any link state.
    logic [ACT_W-1:0] w_act_nxt;

    always_comb begin
        w_act_nxt = r_act;
        if (w_sof_any) begin
            w_act_nxt = c_ACT_LOAD;
        end else if (r_act != '0) begin
            w_act_nxt = r_act - c_ACT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act     <= '0;
            r_led_act <= 1'b0;
        end else begin
            r_act     <= w_act_nxt;
            r_led_act <= (w_act_nxt != '0);
        end
    end

    assign link_up       = r_link_up;
    assign led_link      = r_link_up;
    assign led_act       = r_led_act;
    assign frame_cnt     = r_frame_cnt;
    assign lock_loss_cnt = r_lock_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_rx_link_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_xgmii_rx_link_monitor
// Brief    : Directed and randomized bench for xgmii_rx_link_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xgmii_rx_link_monitor;

    localparam int LC   = 8;
    localparam int AS   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_block_lock = 1'b0;
    logic [63:0]   xgmii_rxd = {8{8'h07}};
    logic [7:0]    xgmii_rxc = 8'hFF;
    logic          clear_cnt = 1'b0;
    logic          link_up;
    logic          led_link;
    logic          led_act;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] lock_loss_cnt;

    xgmii_rx_link_monitor #(
        .LOCK_CYCLES (LC),
        .ACT_STRETCH (AS),
        .CNT_WIDTH   (CW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_block_lock (rx_block_lock),
        .xgmii_rxd     (xgmii_rxd),
        .xgmii_rxc     (xgmii_rxc),
        .clear_cnt     (clear_cnt),
        .link_up       (link_up),
        .led_link      (led_link),
        .led_act       (led_act),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: link is up once the current run of lock-high samples
    // reaches LC; activity is a distance from the most recent start edge.
    int m_run, m_frame, m_err, m_loss, m_edge, m_last_sof;

    task automatic model_reset();
        m_run = 0; m_frame = 0; m_err = 0; m_loss = 0; m_last_sof = -1000;
    endtask

    task automatic model_edge();
        bit was_up;
        int starts;
        bit err_any;
        was_up = (m_run >= LC);
        starts = 0;
        if (xgmii_rxc[0] && xgmii_rxd[7:0] == 8'hFB)   starts++;
        if (xgmii_rxc[4] && xgmii_rxd[39:32] == 8'hFB) starts++;
        err_any = 1'b0;
        for (int k = 0; k < 8; k++)
            if (xgmii_rxc[k] && xgmii_rxd[8*k +: 8] == 8'hFE) err_any = 1'b1;
        if (clear_cnt) begin
            m_frame = 0; m_err = 0; m_loss = 0;
        end else if (was_up) begin
            m_frame = (m_frame + starts > CMAX) ? CMAX : m_frame + starts;
`ifdef LINK_MON_ERR_CNT_EN
            if (err_any) m_err = (m_err + 1 > CMAX) ? CMAX : m_err + 1;
`endif
            if (!rx_block_lock) m_loss = (m_loss + 1 > CMAX) ? CMAX : m_loss + 1;
        end
        m_run = rx_block_lock ? ((m_run < LC) ? m_run + 1 : LC) : 0;
        m_edge++;
        if (starts > 0) m_last_sof = m_edge;
    endtask

    task automatic check_all();
        bit exp_up;
        exp_up = (m_run >= LC);
        check("link_up", 32'(link_up), 32'(exp_up));
        check("led_link", 32'(led_link), 32'(exp_up));
        check("led_act", 32'(led_act), 32'((m_edge - m_last_sof) < AS));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cyc(input bit lock, input bit s0, input bit s4, input bit er, input bit clr);
        xgmii_rxd = {8{8'h07}};
        xgmii_rxc = 8'hFF;
        if (s0) xgmii_rxd[7:0]   = 8'hFB;
        if (s4) xgmii_rxd[39:32] = 8'hFB;
        if (er) xgmii_rxd[23:16] = 8'hFE;
        rx_block_lock = lock;
        clear_cnt     = clr;
        step();
    endtask

    initial begin
        m_edge = 0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Debounce: 5 high, 1 low, then 8 high
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (7) cyc(1, 0, 0, 0, 0);
        check("debounce_pre", 32'(link_up), 32'd0);
        cyc(1, 0, 0, 0, 0);
        check("debounce_up", 32'(link_up), 32'd1);
        check("debounce_loss", 32'(lock_loss_cnt), 32'd0);

        // Frame counting in UP
        cyc(1, 1, 0, 0, 0);
        check("frame_l0", 32'(frame_cnt), 32'd1);
        cyc(1, 0, 1, 0, 0);
        check("frame_l4", 32'(frame_cnt), 32'd2);
        cyc(1, 1, 1, 0, 0);
        check("frame_both", 32'(frame_cnt), 32'd4);

        // Link drop and re-link
        cyc(0, 0, 0, 0, 0);
        check("drop_link", 32'(link_up), 32'd0);
        check("drop_loss", 32'(lock_loss_cnt), 32'd1);
        repeat (7) cyc(1, 0, 0, 0, 0);
        check("relink_pre", 32'(link_up), 32'd0);
        cyc(1, 0, 0, 0, 0);
        check("relink_up", 32'(link_up), 32'd1);

        // Starts while DOWN: no count, LED still pulses
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check("down_frame", 32'(frame_cnt), 32'd4);
        check("down_act", 32'(led_act), 32'd1);

        // Error saturation and clear priority
        repeat (8) cyc(1, 0, 0, 0, 0);
        repeat (20) cyc(1, 0, 0, 1, 0);
`ifdef LINK_MON_ERR_CNT_EN
        check("err_sat", 32'(err_cnt), 32'd15);
`endif
        cyc(1, 0, 0, 1, 1);
        check("err_clear", 32'(err_cnt), 32'd0);

        // Frame saturation on a both-lane start
        repeat (7) cyc(1, 1, 1, 0, 0);
        check("frame_14", 32'(frame_cnt), 32'd14);
        cyc(1, 1, 1, 0, 0);
        check("frame_sat", 32'(frame_cnt), 32'd15);

        // Activity stretch, then re-trigger on the third idle cycle
        repeat (6) cyc(1, 0, 0, 0, 0);
        check("act_idle", 32'(led_act), 32'd0);
        cyc(1, 1, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        check("act_ext_hi", 32'(led_act), 32'd1);
        cyc(1, 0, 0, 0, 0);
        check("act_ext_lo", 32'(led_act), 32'd0);

        // Asynchronous reset between edges while UP
        #2 rst_n = 1'b0;
        #1;
        check("arst_link", 32'(link_up), 32'd0);
        check("arst_frame", 32'(frame_cnt), 32'd0);
        check("arst_loss", 32'(lock_loss_cnt), 32'd0);
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        repeat (7) cyc(1, 0, 0, 0, 0);
        check("arst_relink_pre", 32'(link_up), 32'd0);
        cyc(1, 0, 0, 0, 0);
        check("arst_relink_up", 32'(link_up), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 5))
                    0:       xgmii_rxd[8*k +: 8] = 8'hFB;
                    1:       xgmii_rxd[8*k +: 8] = 8'hFE;
                    2:       xgmii_rxd[8*k +: 8] = 8'h07;
                    default: xgmii_rxd[8*k +: 8] = 8'($urandom);
                endcase
            end
            xgmii_rxc     = 8'($urandom);
            rx_block_lock = ($urandom_range(0, 19) != 0);
            clear_cnt     = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
